// File: rtl/max_pooling.sv
// Streaming 2x2 max-pool: grid LEVEL in, grid LEVEL+1 out, pulse 2 clocks after the LR sample.
// Define POOL_ARGMAX_EN to add out_index (winning quadrant per unit, 00 UL .. 11 LR).

module max_pooling_cmp #(
  parameter int BW = 16
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  output logic          b_win
);
  // strict compare: on equality the earlier sample 'a' keeps the win
  assign b_win = $signed(b) > $signed(a);
endmodule

module max_pooling #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int W_WIDTH    = 800,
  parameter int W_HEIGHT   = 525,
  parameter int FIXED_BITW = 16,
  parameter int UNITS      = 4,
  parameter int LEVEL      = 0
) (
  input  logic                               clock,
  input  logic                               n_rst,
  input  logic                               in_enable,
  input  logic [FIXED_BITW*UNITS-1:0]        in_pixels,
  input  logic [$clog2(W_HEIGHT)-1:0]        in_vcnt,
  input  logic [$clog2(W_WIDTH)-1:0]         in_hcnt,
  output logic                               out_enable,
  output logic [FIXED_BITW*UNITS-1:0]        out_pixels,
  output logic [$clog2(W_HEIGHT)-1:0]        out_vcnt,
  output logic [$clog2(W_WIDTH)-1:0]         out_hcnt
`ifdef POOL_ARGMAX_EN
  ,
  output logic [2*UNITS-1:0]                 out_index
`endif
);
  localparam int VW    = $clog2(W_HEIGHT);
  localparam int HW    = $clog2(W_WIDTH);
  localparam int DW    = FIXED_BITW * UNITS;
  localparam int DEPTH = WIDTH >> (LEVEL + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef POOL_ARGMAX_EN
  localparam int MW    = DW + UNITS;
`else
  localparam int MW    = DW;
`endif

  localparam logic [HW-1:0] H_LIM   = HW'(WIDTH);
  localparam logic [VW-1:0] V_LIM   = VW'(HEIGHT);
  localparam logic [HW-1:0] H_LOW   = HW'((1 << LEVEL) - 1);
  localparam logic [VW-1:0] V_LOW   = VW'((1 << LEVEL) - 1);
  localparam logic [HW-1:0] H_KEEP  = ~HW'((1 << (LEVEL + 1)) - 1);
  localparam logic [VW-1:0] V_KEEP  = ~VW'((1 << (LEVEL + 1)) - 1);
  localparam logic [HW-1:0] H_DEPTH = HW'(DEPTH);

  typedef enum logic [1:0] {IDLE, TOP, BOTTOM} row_state_t;

  row_state_t        state;
  logic              accept, q_bottom, q_right, new_top, in_range, pair, top_wr, lr_fire;
  logic [HW-1:0]     addr_full;
  logic [AW-1:0]     addr;
  logic              left_valid;
  logic [DEPTH-1:0]  vbit;
  logic [DW-1:0]     hold, hmax, vmax;
  logic [UNITS-1:0]  hwin, vwin;
  logic [MW-1:0]     mem [DEPTH];
  logic [MW-1:0]     rd_q, wr_word;
  logic [DW-1:0]     s1_hmax;
  logic [VW-1:0]     s1_vcnt;
  logic [HW-1:0]     s1_hcnt;
  logic [1:0]        vld_pipe;

  assign accept    = in_enable && (in_hcnt < H_LIM) && (in_vcnt < V_LIM) &&
                     ((in_hcnt & H_LOW) == '0) && ((in_vcnt & V_LOW) == '0);
  assign q_bottom  = in_vcnt[LEVEL];
  assign q_right   = in_hcnt[LEVEL];
  assign addr_full = in_hcnt >> (LEVEL + 1);
  assign addr      = addr_full[AW-1:0];
  assign in_range  = addr_full < H_DEPTH;
  assign new_top   = accept && !q_bottom && (state != TOP);
  // a new top row invalidates any left sample held over from the previous row pair
  assign pair      = accept && q_right && left_valid && !new_top && in_range;
  assign top_wr    = pair && !q_bottom;
  assign lr_fire   = pair && q_bottom && vbit[addr];
  assign out_enable = vld_pipe[1];

`ifdef POOL_ARGMAX_EN
  logic [UNITS-1:0]   s1_hwin;
  logic [2*UNITS-1:0] idx_d;
  assign wr_word = {hwin, hmax};
`else
  assign wr_word = hmax;
`endif

  for (genvar u = 0; u < UNITS; u++) begin : g_unit
    localparam int LSB = (UNITS - 1 - u) * FIXED_BITW;
    logic [FIXED_BITW-1:0] l_px, r_px, t_px, b_px;
    assign l_px = hold[LSB +: FIXED_BITW];
    assign r_px = in_pixels[LSB +: FIXED_BITW];
    assign t_px = rd_q[LSB +: FIXED_BITW];
    assign b_px = s1_hmax[LSB +: FIXED_BITW];
    max_pooling_cmp #(.BW(FIXED_BITW)) u_hcmp (.a(l_px), .b(r_px), .b_win(hwin[u]));
    max_pooling_cmp #(.BW(FIXED_BITW)) u_vcmp (.a(t_px), .b(b_px), .b_win(vwin[u]));
    assign hmax[LSB +: FIXED_BITW] = hwin[u] ? r_px : l_px;
    assign vmax[LSB +: FIXED_BITW] = vwin[u] ? b_px : t_px;
`ifdef POOL_ARGMAX_EN
    assign idx_d[2*(UNITS-1-u) +: 2] = vwin[u] ? {1'b1, s1_hwin[u]} : {1'b0, rd_q[DW+u]};
`endif
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      state      <= IDLE;
      left_valid <= 1'b0;
      vbit       <= '0;
      vld_pipe   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], lr_fire};
      if (!in_enable && in_vcnt == '0 && in_hcnt == '0)
        state <= IDLE;
      else if (accept) begin
        if (!q_bottom && state != TOP)     state <= TOP;
        else if (q_bottom && state == TOP) state <= BOTTOM;
      end
      if (new_top) begin
        vbit       <= '0;
        left_valid <= 1'b0;
      end
      if (accept) left_valid <= !q_right;
      if (top_wr)  vbit[addr] <= 1'b1;
      if (lr_fire) vbit[addr] <= 1'b0;
    end
  end

  // datapath storage carries no reset; validity is tracked by the flags above
  always_ff @(posedge clock) begin
    if (accept && !q_right) hold <= in_pixels;
    if (top_wr) mem[addr] <= wr_word;
    if (accept) rd_q <= mem[addr];
    if (lr_fire) begin
      s1_hmax <= hmax;
      s1_vcnt <= in_vcnt & V_KEEP;
      s1_hcnt <= in_hcnt & H_KEEP;
`ifdef POOL_ARGMAX_EN
      s1_hwin <= hwin;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      out_pixels <= '0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
`ifdef POOL_ARGMAX_EN
      out_index  <= '0;
`endif
    end else if (vld_pipe[0]) begin
      out_pixels <= vmax;
      out_vcnt   <= s1_vcnt;
      out_hcnt   <= s1_hcnt;
`ifdef POOL_ARGMAX_EN
      out_index  <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_max_pooling.sv
// Directed bench for max_pooling: instance 0 LEVEL 0 4x2, instance 1 LEVEL 1 8x4, instance 2 LEVEL 0 5x2.
`timescale 1ns/1ps
module tb_max_pooling;
  localparam int B  = 16;
  localparam int U  = 2;
  localparam int DW = B * U;

  logic                  clock = 1'b0;
  logic                  n_rst = 1'b0;
  logic [2:0]            en    = '0;
  logic [DW-1:0]         pix   = '0;
  logic [9:0]            vcnt  = '0;
  logic [9:0]            hcnt  = '0;
  logic [2:0]            oe;
  logic [2:0][DW-1:0]    op;
  logic [2:0][9:0]       ov, oh;
`ifdef POOL_ARGMAX_EN
  logic [2:0][2*U-1:0]   oi;
`endif
  int checks = 0;
  int errors = 0;
  int pulses [3] = '{0, 0, 0};

  always #5 clock = ~clock;

  max_pooling #(.WIDTH(4), .HEIGHT(2), .FIXED_BITW(B), .UNITS(U), .LEVEL(0)) dut0 (
    .clock(clock), .n_rst(n_rst), .in_enable(en[0]), .in_pixels(pix), .in_vcnt(vcnt),
    .in_hcnt(hcnt), .out_enable(oe[0]), .out_pixels(op[0]), .out_vcnt(ov[0]), .out_hcnt(oh[0])
`ifdef POOL_ARGMAX_EN
    , .out_index(oi[0])
`endif
  );
  max_pooling #(.WIDTH(8), .HEIGHT(4), .FIXED_BITW(B), .UNITS(U), .LEVEL(1)) dut1 (
    .clock(clock), .n_rst(n_rst), .in_enable(en[1]), .in_pixels(pix), .in_vcnt(vcnt),
    .in_hcnt(hcnt), .out_enable(oe[1]), .out_pixels(op[1]), .out_vcnt(ov[1]), .out_hcnt(oh[1])
`ifdef POOL_ARGMAX_EN
    , .out_index(oi[1])
`endif
  );
  max_pooling #(.WIDTH(5), .HEIGHT(2), .FIXED_BITW(B), .UNITS(U), .LEVEL(0)) dut2 (
    .clock(clock), .n_rst(n_rst), .in_enable(en[2]), .in_pixels(pix), .in_vcnt(vcnt),
    .in_hcnt(hcnt), .out_enable(oe[2]), .out_pixels(op[2]), .out_vcnt(ov[2]), .out_hcnt(oh[2])
`ifdef POOL_ARGMAX_EN
    , .out_index(oi[2])
`endif
  );

  always @(negedge clock) begin
    if (oe[0]) pulses[0]++;
    if (oe[1]) pulses[1]++;
    if (oe[2]) pulses[2]++;
  end

  function automatic logic [DW-1:0] pk(input int a, input int b);
    return {16'(a), 16'(b)};
  endfunction

  task automatic px(input int d, input int v, input int h, input int a0, input int a1);
    @(negedge clock);
    en = '0;
    en[d] = 1'b1;
    vcnt = 10'(v);
    hcnt = 10'(h);
    pix = pk(a0, a1);
  endtask

  task automatic idle();
    @(negedge clock);
    en = '0;
    vcnt = '0;
    hcnt = '0;
  endtask

  task automatic chk(input string tag, input int d, input int e_oe, input logic [DW-1:0] e_px,
                     input int e_v, input int e_h);
    checks++;
    assert (oe[d] === 1'(e_oe)) else begin
      errors++; $error("FAIL %s out_enable: got %b expected %b", tag, oe[d], 1'(e_oe));
    end
    checks++;
    assert (op[d] === e_px) else begin
      errors++; $error("FAIL %s out_pixels: got %h expected %h", tag, op[d], e_px);
    end
    checks++;
    assert (ov[d] === 10'(e_v) && oh[d] === 10'(e_h)) else begin
      errors++; $error("FAIL %s coords: got v%0d h%0d expected v%0d h%0d", tag, ov[d], oh[d], e_v, e_h);
    end
  endtask

`ifdef POOL_ARGMAX_EN
  task automatic chki(input string tag, input int d, input int e_idx);
    checks++;
    assert (oi[d] === 4'(e_idx)) else begin
      errors++; $error("FAIL %s out_index: got %b expected %b", tag, oi[d], 4'(e_idx));
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) chk("reset", d, 0, '0, 0, 0);
`ifdef POOL_ARGMAX_EN
    for (int d = 0; d < 3; d++) chki("reset_idx", d, 0);
`endif
    n_rst = 1'b1;

    // basic 4x2 frame: unit0 {1,5,-3,2 / 4,0,-1,-7}, unit1 {10,3,7,7 / 2,11,-4,8}
    px(0, 0, 0, 1, 10);  px(0, 0, 1, 5, 3);  px(0, 0, 2, -3, 7); px(0, 0, 3, 2, 7);
    px(0, 1, 0, 4, 2);   px(0, 1, 1, 0, 11);
    px(0, 1, 2, -1, -4); chk("basic_lat1", 0, 0, pk(0, 0), 0, 0);
    px(0, 1, 3, -7, 8);  chk("basic_out0", 0, 1, pk(5, 11), 0, 0);
`ifdef POOL_ARGMAX_EN
    chki("basic_idx0", 0, 4'b0111);
`endif
    idle();              chk("basic_gap", 0, 0, pk(5, 11), 0, 0);
    idle();              chk("basic_out1", 0, 1, pk(2, 8), 0, 2);
`ifdef POOL_ARGMAX_EN
    chki("basic_idx1", 0, 4'b0111);
`endif
    idle();              chk("basic_hold", 0, 0, pk(2, 8), 0, 2);

    // all-equal unit0 and all-negative unit1
    px(0, 0, 0, 9, -8); px(0, 0, 1, 9, -2); px(0, 1, 0, 9, -5); px(0, 1, 1, 9, -6);
    idle();             chk("tie_gap", 0, 0, pk(2, 8), 0, 2);
    idle();             chk("tie_neg", 0, 1, pk(9, -2), 0, 0);
`ifdef POOL_ARGMAX_EN
    chki("tie_neg_idx", 0, 4'b0001);
`endif

    // reset between the top and bottom rows loses the group
    px(0, 0, 2, 20, 20); px(0, 0, 3, 21, 21);
    @(negedge clock); en = '0; vcnt = '0; hcnt = '0; n_rst = 1'b0;
    @(negedge clock); chk("midrst", 0, 0, '0, 0, 0);
    n_rst = 1'b1;
    px(0, 1, 2, 22, 22); px(0, 1, 3, 23, 23);
    idle(); chk("midrst_q1", 0, 0, '0, 0, 0);
    idle(); chk("midrst_q2", 0, 0, '0, 0, 0);
    idle(); chk("midrst_q3", 0, 0, '0, 0, 0);
    px(0, 0, 2, 3, 0); px(0, 0, 3, -1, 0); px(0, 1, 2, 7, 0); px(0, 1, 3, 7, 1);
    idle(); chk("postrst_gap", 0, 0, '0, 0, 0);
    idle(); chk("postrst_out", 0, 1, pk(7, 1), 0, 2);
`ifdef POOL_ARGMAX_EN
    chki("postrst_idx", 0, 4'b1011);
`endif

    // LEVEL 1: only even coordinates count; decoys carry 100
    px(1, 0, 4, 1, 5);
    px(1, 0, 5, 100, 100);
    px(1, 1, 4, 100, 100);
    px(1, 0, 6, 2, 5);
    px(1, 0, 7, 100, 100);
    px(1, 2, 4, 3, 5);
    px(1, 2, 5, 100, 100);
    px(1, 3, 6, 100, 100);
    px(1, 2, 6, -4, 5);
    px(1, 2, 7, 100, 100); chk("lvl1_gap", 1, 0, '0, 0, 0);
    idle();                chk("lvl1_out", 1, 1, pk(3, 5), 0, 4);
`ifdef POOL_ARGMAX_EN
    chki("lvl1_idx", 1, 4'b1000);
`endif

    // odd WIDTH=5: column 4 never pairs
    px(2, 0, 0, 1, 0); px(2, 0, 1, 2, 0); px(2, 0, 2, 3, 0); px(2, 0, 3, 4, 0); px(2, 0, 4, 50, 0);
    px(2, 1, 0, 5, 0); px(2, 1, 1, 6, 0);
    px(2, 1, 2, 7, 0);  chk("odd_gap0", 2, 0, '0, 0, 0);
    px(2, 1, 3, 8, 0);  chk("odd_out0", 2, 1, pk(6, 0), 0, 0);
`ifdef POOL_ARGMAX_EN
    chki("odd_idx0", 2, 4'b1100);
`endif
    px(2, 1, 4, 60, 0); chk("odd_gap1", 2, 0, pk(6, 0), 0, 0);
    idle();             chk("odd_out1", 2, 1, pk(8, 0), 0, 2);
    idle();             chk("odd_col4a", 2, 0, pk(8, 0), 0, 2);
    idle();             chk("odd_col4b", 2, 0, pk(8, 0), 0, 2);
    repeat (3) idle();

    checks++;
    assert (pulses[0] == 4) else begin
      errors++; $error("FAIL pulses0: got %0d expected 4", pulses[0]);
    end
    checks++;
    assert (pulses[1] == 1) else begin
      errors++; $error("FAIL pulses1: got %0d expected 1", pulses[1]);
    end
    checks++;
    assert (pulses[2] == 2) else begin
      errors++; $error("FAIL pulses2: got %0d expected 2", pulses[2]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
